// File: rtl/avalon_wb_bridge_pkg.sv
// Shared constants and state encodings for the Avalon-MM to Wishbone burst bridge.
package avalon_wb_bridge_pkg;

  // Wishbone cycle type identifiers
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Wishbone burst type extension: only linear bursts are generated
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  // Avalon response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Bridge control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } bridgeState_e;

endpackage

// File: rtl/wb_burst_addr_gen.sv
// Beat counter and incrementing address generator for one Wishbone burst.
// A load captures the base address and beat count (a count of zero means one
// beat); each step advances the address by one data word and retires a beat.
module wb_burst_addr_gen
  import avalon_wb_bridge_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int BCW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic [AW-1:0]  base_i,
  input  logic [BCW-1:0] count_i,
  input  logic           step_i,
  output logic [AW-1:0]  adr_o,
  output logic           last_o
);

  localparam logic [AW-1:0] STRIDE = AW'(DW / 8);

  logic [AW-1:0]  adr_q, adr_d;
  logic [BCW-1:0] remaining_q, remaining_d;

  // Next address/count: load wins over step; address wraps modulo 2^AW
  always_comb begin
    adr_d       = adr_q;
    remaining_d = remaining_q;
    if (load_i) begin
      adr_d       = base_i;
      remaining_d = (count_i == '0) ? BCW'(1) : count_i;
    end else if (step_i) begin
      adr_d       = adr_q + STRIDE;
      remaining_d = remaining_q - BCW'(1);
    end
  end

  // Address and beat counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      adr_q       <= '0;
      remaining_q <= '0;
    end else begin
      adr_q       <= adr_d;
      remaining_q <= remaining_d;
    end
  end

  assign adr_o  = adr_q;
  assign last_o = (remaining_q <= BCW'(1));

endmodule

// File: rtl/avalon_to_wb_burst_bridge.sv
// Avalon-MM slave to Wishbone B3 master bridge with incrementing bursts.
// Reads are accepted immediately from IDLE and return registered data; writes
// stall in IDLE and then pass each beat straight through, releasing
// waitrequest in the same cycle the slave acknowledges it.
module avalon_to_wb_burst_bridge
  import avalon_wb_bridge_pkg::*;
#(
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int BCW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   avm_address_i,
  input  logic [DW/8-1:0] avm_byteenable_i,
  input  logic            avm_read_i,
  input  logic            avm_write_i,
  input  logic [BCW-1:0]  avm_burstcount_i,
  input  logic [DW-1:0]   avm_writedata_i,
  output logic            avm_waitrequest_o,
  output logic [DW-1:0]   avm_readdata_o,
  output logic            avm_readdatavalid_o,
  output logic [1:0]      avm_response_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic            wbm_we_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic [2:0]      wbm_cti_o,
  output logic [1:0]      wbm_bte_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i,
  input  logic            wbm_err_i,
  input  logic            wbm_rty_i
);

  bridgeState_e state_q, state_d;

  logic [DW/8-1:0] be_q, be_d;
  logic [DW-1:0]   rdData_q, rdData_d;
  logic [1:0]      rdResp_q, rdResp_d;
  logic            rdValid_q, rdValid_d;

  logic            loadAddr;
  logic            stepAddr;
  logic            lastBeat;
  logic            beatDone;

  // A beat completes on ack or err; a retry never completes it
  assign beatDone = (wbm_ack_i | wbm_err_i) & ~wbm_rty_i;

  wb_burst_addr_gen #(
    .AW  (AW),
    .DW  (DW),
    .BCW (BCW)
  ) addrGen (
    .clk     (clk),
    .rst     (rst),
    .load_i  (loadAddr),
    .base_i  (avm_address_i),
    .count_i (avm_burstcount_i),
    .step_i  (stepAddr),
    .adr_o   (wbm_adr_o),
    .last_o  (lastBeat)
  );

  // Next-state logic and all combinational bus outputs
  always_comb begin
    state_d           = state_q;
    be_d              = be_q;
    rdData_d          = rdData_q;
    rdResp_d          = rdResp_q;
    rdValid_d         = 1'b0;
    loadAddr          = 1'b0;
    stepAddr          = 1'b0;
    avm_waitrequest_o = 1'b1;
    avm_response_o    = rdResp_q;
    wbm_cyc_o         = 1'b0;
    wbm_stb_o         = 1'b0;
    wbm_we_o          = 1'b0;
    wbm_sel_o         = '0;
    wbm_dat_o         = '0;
    wbm_cti_o         = CTI_CLASSIC;
    wbm_bte_o         = BTE_LINEAR;

    case (state_q)
      IDLE: begin
        if (avm_read_i) begin
          avm_waitrequest_o = 1'b0;
          loadAddr          = 1'b1;
          be_d              = avm_byteenable_i;
          state_d           = READ;
        end else if (avm_write_i) begin
          loadAddr = 1'b1;
          state_d  = WRITE;
        end
      end

      READ: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_sel_o = be_q;
        wbm_cti_o = lastBeat ? CTI_EOB : CTI_INC;
        if (beatDone) begin
          stepAddr  = 1'b1;
          rdData_d  = wbm_dat_i;
          rdResp_d  = wbm_err_i ? RESP_SLVERR : RESP_OKAY;
          rdValid_d = 1'b1;
          if (lastBeat) begin
            state_d = IDLE;
          end
        end
      end

      WRITE: begin
        wbm_cyc_o         = 1'b1;
        wbm_stb_o         = avm_write_i;
        wbm_we_o          = avm_write_i;
        wbm_sel_o         = avm_byteenable_i;
        wbm_dat_o         = avm_writedata_i;
        wbm_cti_o         = lastBeat ? CTI_EOB : CTI_INC;
        avm_waitrequest_o = ~beatDone;
        avm_response_o    = wbm_err_i ? RESP_SLVERR : RESP_OKAY;
        if (avm_write_i && beatDone) begin
          stepAddr = 1'b1;
          if (lastBeat) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched byteenable and registered read-return path
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      be_q      <= '0;
      rdData_q  <= '0;
      rdResp_q  <= RESP_OKAY;
      rdValid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      be_q      <= be_d;
      rdData_q  <= rdData_d;
      rdResp_q  <= rdResp_d;
      rdValid_q <= rdValid_d;
    end
  end

  assign avm_readdata_o      = rdData_q;
  assign avm_readdatavalid_o = rdValid_q;

endmodule
